request_unit: RTL and testbench
===============================

# request_unit

Sequencer between the control unit's decoded memory-request signals and the cache-side memory interface. It turns per-instruction decode outputs (iMemRe, dMemRe, dMemWr, Halt, regWEN) into held memory requests that survive across multi-cycle cache misses. It gates PC advance and register write-back until the instruction has fully completed. It also latches halt stickily and counts retired instructions.

## Interface
- RETIRE_W, 32, width of retired-instruction counter
- TIMEOUT_CYCLES, 255, max DATA-state wait before timeout (only with REQUEST_UNIT_TIMEOUT_EN)

- CLK  in  1  system clock, rising-edge
- RST  in  1  reset, asynchronous, active-high
- iMemRe  in  1  control-unit fetch enable (qualifies FETCH; 0 = stall fetch)
- dMemRe  in  1  control-unit decode: instruction loads
- dMemWr  in  1  control-unit decode: instruction stores
- Halt  in  1  control-unit decode: halt instruction
- regWEN_in  in  1  control-unit decode: instruction writes a register
- ihit  in  1  instruction word valid this cycle
- dhit  in  1  data access complete this cycle
- imemREN  out  1  instruction read request
- dmemREN  out  1  data read request (held)
- dmemWEN  out  1  data write request (held)
- pcEN  out  1  one-cycle pulse: advance PC
- regWEN  out  1  one-cycle pulse: commit register write
- halt  out  1  sticky halt
- retire_cnt  out  RETIRE_W  retired instructions, wraps
- timeout_err  out  1  sticky data-wait timeout (0 when macro absent)

## Operation
- States: FETCH, DATA, HALTED. Reset state FETCH.
- FETCH: imemREN = iMemRe. Decode inputs are valid only when ihit=1.
  - ihit & Halt -> HALTED. No pcEN, no regWEN, no retire increment.
  - ihit & (dMemRe|dMemWr) -> DATA. Latch rd=dMemRe, wr=dMemWr, wen=regWEN_in. If both are set, write wins (rd latched 0).
  - ihit, otherwise -> stay in FETCH. pcEN=1 and regWEN=regWEN_in the same cycle. retire_cnt increments.
  - dhit in FETCH is ignored.
- DATA: imemREN=0. dmemREN=rd and dmemWEN=wr are held constant until dhit.
  - On dhit: pcEN=1, regWEN=latched wen, retire_cnt++, clear latches, go to FETCH.
  - ihit in DATA is ignored.
- HALTED: terminal until RST. halt=1. All request, pcEN and regWEN outputs are 0. Hits are ignored.
- retire_cnt: modulo 2^RETIRE_W. 2^RETIRE_W-1 + 1 -> 0. No saturation.
- Reset (any time, including mid-DATA): state=FETCH; rd/wr/wen latches=0; dmemREN=dmemWEN=0; halt=0; retire_cnt=0; timeout_err=0; pcEN=regWEN=0. imemREN follows iMemRe from the reset state.

## Timing
- imemREN, pcEN, regWEN: combinational from state plus the same-cycle inputs.
- dmemREN/dmemWEN: registered; first asserted the cycle after the qualifying ihit.
- Deasserted combinationally in the dhit cycle; 0 in the next cycle.
- Non-memory instruction: retires in the ihit cycle (0 extra cycles).
- Memory instruction: retires in the dhit cycle. Minimum 1 cycle after ihit.
- pcEN and regWEN are never high for more than 1 consecutive cycle per instruction.
- halt rises the cycle after the halting ihit and stays high.
- Only one request (imemREN, dmemREN, dmemWEN) is ever asserted at a time.

## Configuration
- Macro REQUEST_UNIT_TIMEOUT_EN.
- Defined:
  - A counter clears on DATA entry and increments each DATA cycle without dhit.
  - When it reaches TIMEOUT_CYCLES: timeout_err=1 (sticky), state -> HALTED, halt=1.
  - pcEN and retire are suppressed for that instruction.
  - dhit arriving in the same cycle as the limit is reached wins: normal retire, no error.
- Undefined: no counter logic; timeout_err tied 0; DATA waits indefinitely.

## Test plan
- Reset mid-DATA: assert RST while dmemREN=1 -> dmemREN=0, state FETCH, retire_cnt=0, imemREN=1 with iMemRe=1.
- ALU op: ihit=1, regWEN_in=1, no mem -> pcEN=1 and regWEN=1 in the same cycle, retire_cnt 0->1.
- Load, 3-cycle miss: ihit with dMemRe=1, regWEN_in=1; inputs change after -> dmemREN=1 for 3 cycles. dhit on cycle 3 -> pcEN=regWEN=1 once, dmemREN=0 next cycle.
- Store, dMemRe=dMemWr=1, regWEN_in=0: dmemWEN=1, dmemREN=0. On dhit -> pcEN=1, regWEN=0. Spurious ihit during DATA has no effect.
- Halt: ihit with Halt=1 -> halt=1 next cycle; further ihit/dhit -> no pcEN, retire_cnt unchanged. retire_cnt preloaded via 2^RETIRE_W retires wraps to 0.
- With REQUEST_UNIT_TIMEOUT_EN and TIMEOUT_CYCLES=4: load with no dhit -> timeout_err=1 and halt=1 after 4 DATA cycles. Repeat with dhit on the 4th cycle -> normal retire, timeout_err=0.

Source files
------------

// File: rtl/request_unit.sv
// request_unit
//   Sequencer between the control unit's decoded memory-request signals and
//   the cache-side memory interface. Fetch-side decode is accepted on ihit;
//   a load or store is turned into a held data request that survives a
//   multi-cycle miss, and PC advance / register write-back are issued as a
//   single-cycle pulse only once the instruction has fully completed.
//   A halt instruction parks the unit in a terminal state until RST.
//
// Configuration macro:
//   REQUEST_UNIT_TIMEOUT_EN - when defined, a DATA-state wait longer than
//   TIMEOUT_CYCLES without dhit sets sticky timeout_err and halts the unit.
//   When undefined, DATA waits indefinitely and timeout_err is tied 0.
//
// Ports:
//   CLK, RST             clock (rising edge), asynchronous active-high reset
//   iMemRe               fetch enable, drives imemREN while fetching
//   dMemRe, dMemWr       decoded load / store
//   Halt                 decoded halt instruction
//   regWEN_in            decoded register write
//   ihit, dhit           instruction word valid / data access complete
//   imemREN              instruction read request
//   dmemREN, dmemWEN     held data read / write requests
//   pcEN, regWEN         one-cycle retire pulses
//   halt                 sticky halt
//   retire_cnt           retired-instruction counter, wraps
//   timeout_err          sticky data-wait timeout
module request_unit #(
  parameter int RETIRE_W       = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                iMemRe,
  input  logic                dMemRe,
  input  logic                dMemWr,
  input  logic                Halt,
  input  logic                regWEN_in,
  input  logic                ihit,
  input  logic                dhit,
  output logic                imemREN,
  output logic                dmemREN,
  output logic                dmemWEN,
  output logic                pcEN,
  output logic                regWEN,
  output logic                halt,
  output logic [RETIRE_W-1:0] retire_cnt,
  output logic                timeout_err
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state, state_next;

  // Latched request for the instruction currently waiting in DATA.
  logic rd, wr, wen;

  logic mem_op;      // decoded instruction needs the data side
  logic data_enter;  // accepted memory instruction this cycle
  logic retire;      // instruction completes this cycle
  logic wait_limit;  // DATA wait expired without dhit this cycle

  assign mem_op     = dMemRe | dMemWr;
  assign data_enter = (state == FETCH) && ihit && !Halt && mem_op;

`ifdef REQUEST_UNIT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;

  // The limit is reached in the cycle whose increment would make the count
  // equal TIMEOUT_CYCLES; a dhit in that same cycle takes priority.
  assign wait_limit = (state == DATA) && !dhit &&
                      (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (data_enter) begin
        wait_cnt <= '0;
      end else if ((state == DATA) && !dhit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_limit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wait_limit         = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FETCH;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      state <= state_next;
    end
  end

  // Next-state logic. Halt has priority over a simultaneous memory decode.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    state_next = state;
    unique case (state)
      FETCH: begin
        if (ihit && Halt)        state_next = HALTED;
        else if (ihit && mem_op) state_next = DATA;
      end
      DATA: begin
        if (dhit)            state_next = FETCH;
        else if (wait_limit) state_next = HALTED;
      end
      HALTED:  state_next = HALTED;
      default: state_next = FETCH;
    endcase
  end

  // Output logic. Data requests drop combinationally in the dhit cycle so
  // they are never seen alongside imemREN after the return to FETCH.
  always_comb begin
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    pcEN    = 1'b0;
    regWEN  = 1'b0;
    halt    = 1'b0;
    retire  = 1'b0;
    unique case (state)
      FETCH: begin
        imemREN = iMemRe;
        if (ihit && !Halt && !mem_op) begin
          pcEN   = 1'b1;
          regWEN = regWEN_in;
          retire = 1'b1;
        end
      end
      DATA: begin
        dmemREN = rd & ~dhit;
        dmemWEN = wr & ~dhit;
        if (dhit) begin
          pcEN   = 1'b1;
          regWEN = wen;
          retire = 1'b1;
        end
      end
      HALTED:  halt = 1'b1;
      default: ;
    endcase
  end

  // Request latches and retire counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd         <= 1'b0;
      wr         <= 1'b0;
      wen        <= 1'b0;
      retire_cnt <= '0;
    end else begin
      if (data_enter) begin
        // A store wins when both load and store are decoded.
        rd  <= dMemRe & ~dMemWr;
        wr  <= dMemWr;
        wen <= regWEN_in;
      end else if ((state == DATA) && (dhit || wait_limit)) begin
        rd  <= 1'b0;
        wr  <= 1'b0;
        wen <= 1'b0;
      end
      if (retire) begin
        retire_cnt <= retire_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit
//   Directed bench for request_unit. Uses a 4-bit retire counter so the wrap
//   boundary is reachable, and a 4-cycle timeout limit for the optional
//   REQUEST_UNIT_TIMEOUT_EN build. Inputs change on the falling edge and
//   outputs are sampled 1 ns later, well clear of the rising edge.
module tb_request_unit;

  localparam int RW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          iMemRe, dMemRe, dMemWr, Halt, regWEN_in, ihit, dhit;
  logic          imemREN, dmemREN, dmemWEN, pcEN, regWEN, halt, timeout_err;
  logic [RW-1:0] retire_cnt;

  int vectors     = 0;
  int miscompares = 0;

  request_unit #(
    .RETIRE_W      (RW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .iMemRe     (iMemRe),
    .dMemRe     (dMemRe),
    .dMemWr     (dMemWr),
    .Halt       (Halt),
    .regWEN_in  (regWEN_in),
    .ihit       (ihit),
    .dhit       (dhit),
    .imemREN    (imemREN),
    .dmemREN    (dmemREN),
    .dmemWEN    (dmemWEN),
    .pcEN       (pcEN),
    .regWEN     (regWEN),
    .halt       (halt),
    .retire_cnt (retire_cnt),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clear_inputs();
    dMemRe = 1'b0; dMemWr = 1'b0; Halt = 1'b0;
    regWEN_in = 1'b0; ihit = 1'b0; dhit = 1'b0;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    #1;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    iMemRe = 1'b1;
    clear_inputs();

    // Reset state
    #2;
    check("rst_imemREN", imemREN, 1);
    check("rst_dmemREN", dmemREN, 0);
    check("rst_dmemWEN", dmemWEN, 0);
    check("rst_pcEN", pcEN, 0);
    check("rst_regWEN", regWEN, 0);
    check("rst_halt", halt, 0);
    check("rst_retire", retire_cnt, 0);
    check("rst_timeout", timeout_err, 0);
    @(negedge CLK);
    RST = 1'b0;

    // ALU op retires in the ihit cycle
    ihit = 1'b1; regWEN_in = 1'b1;
    #1;
    check("alu_pcEN", pcEN, 1);
    check("alu_regWEN", regWEN, 1);
    check("alu_imemREN", imemREN, 1);
    @(negedge CLK);
    clear_inputs();
    #1;
    check("alu_retire", retire_cnt, 1);
    check("alu_pcEN_drop", pcEN, 0);

    // Load with a 3-cycle miss; decode inputs change after ihit
    ihit = 1'b1; dMemRe = 1'b1; regWEN_in = 1'b1;
    #1;
    check("ld_ihit_pcEN", pcEN, 0);
    check("ld_ihit_regWEN", regWEN, 0);
    check("ld_ihit_dmemREN", dmemREN, 0);
    @(negedge CLK);
    clear_inputs();
    #1;
    check("ld_c1_dmemREN", dmemREN, 1);
    check("ld_c1_dmemWEN", dmemWEN, 0);
    check("ld_c1_imemREN", imemREN, 0);
    check("ld_c1_pcEN", pcEN, 0);
    @(negedge CLK);
    #1;
    check("ld_c2_dmemREN", dmemREN, 1);
    @(negedge CLK);
    #1;
    check("ld_c3_dmemREN", dmemREN, 1);
    dhit = 1'b1;
    #1;
    check("ld_dhit_pcEN", pcEN, 1);
    check("ld_dhit_regWEN", regWEN, 1);
    check("ld_dhit_dmemREN", dmemREN, 0);
    @(negedge CLK);
    dhit = 1'b0;
    #1;
    check("ld_after_dmemREN", dmemREN, 0);
    check("ld_after_imemREN", imemREN, 1);
    check("ld_after_pcEN", pcEN, 0);
    check("ld_retire", retire_cnt, 2);

    // Load+store decode: store wins; spurious ihit in DATA ignored
    ihit = 1'b1; dMemRe = 1'b1; dMemWr = 1'b1;
    @(negedge CLK);
    clear_inputs();
    ihit = 1'b1;
    #1;
    check("st_dmemWEN", dmemWEN, 1);
    check("st_dmemREN", dmemREN, 0);
    check("st_spur_pcEN", pcEN, 0);
    check("st_imemREN", imemREN, 0);
    @(negedge CLK);
    ihit = 1'b0; dhit = 1'b1;
    #1;
    check("st_dhit_pcEN", pcEN, 1);
    check("st_dhit_regWEN", regWEN, 0);
    check("st_dhit_dmemWEN", dmemWEN, 0);
    @(negedge CLK);
    dhit = 1'b0;
    #1;
    check("st_retire", retire_cnt, 3);
    check("st_after_dmemWEN", dmemWEN, 0);

    // Reset in the middle of a load
    ihit = 1'b1; dMemRe = 1'b1; regWEN_in = 1'b1;
    @(negedge CLK);
    clear_inputs();
    #1;
    check("mid_pre_dmemREN", dmemREN, 1);
    RST = 1'b1;
    #1;
    check("mid_dmemREN", dmemREN, 0);
    check("mid_imemREN", imemREN, 1);
    check("mid_retire", retire_cnt, 0);
    @(negedge CLK);
    RST = 1'b0;

    // 15 back-to-back ALU retires, then the 16th wraps to 0
    ihit = 1'b1;
    repeat (15) @(negedge CLK);
    ihit = 1'b0;
    #1;
    check("wrap_max", retire_cnt, 15);
    ihit = 1'b1;
    #1;
    check("wrap_pcEN", pcEN, 1);
    @(negedge CLK);
    ihit = 1'b0;
    #1;
    check("wrap_zero", retire_cnt, 0);

    // dhit while fetching is ignored
    dhit = 1'b1;
    #1;
    check("fdhit_pcEN", pcEN, 0);
    @(negedge CLK);
    dhit = 1'b0;
    #1;
    check("fdhit_retire", retire_cnt, 0);

    // Halt: no retire on the halting ihit; everything ignored afterwards
    ihit = 1'b1; Halt = 1'b1; regWEN_in = 1'b1;
    #1;
    check("hlt_pcEN", pcEN, 0);
    check("hlt_regWEN", regWEN, 0);
    check("hlt_halt_same", halt, 0);
    @(negedge CLK);
    Halt = 1'b0; dhit = 1'b1; dMemRe = 1'b1;
    #1;
    check("hlt_halt", halt, 1);
    check("hlt_post_pcEN", pcEN, 0);
    check("hlt_post_regWEN", regWEN, 0);
    check("hlt_post_imemREN", imemREN, 0);
    check("hlt_post_dmemREN", dmemREN, 0);
    @(negedge CLK);
    #1;
    check("hlt_retire", retire_cnt, 0);
    check("hlt_sticky", halt, 1);
    check("hlt_timeout", timeout_err, 0);
    clear_inputs();

`ifdef REQUEST_UNIT_TIMEOUT_EN
    // Load with no dhit times out after 4 DATA cycles
    @(negedge CLK);
    pulse_reset();
    ihit = 1'b1; dMemRe = 1'b1; regWEN_in = 1'b1;
    @(negedge CLK);
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("to_wait_err", timeout_err, 0);
      check("to_wait_halt", halt, 0);
      check("to_wait_dmemREN", dmemREN, 1);
      @(negedge CLK);
    end
    #1;
    check("to_err", timeout_err, 1);
    check("to_halt", halt, 1);
    check("to_dmemREN", dmemREN, 0);
    check("to_retire", retire_cnt, 0);

    // dhit in the 4th DATA cycle wins over the timeout
    pulse_reset();
    ihit = 1'b1; dMemRe = 1'b1; regWEN_in = 1'b1;
    @(negedge CLK);
    clear_inputs();
    repeat (3) @(negedge CLK);
    dhit = 1'b1;
    #1;
    check("tod_pcEN", pcEN, 1);
    check("tod_regWEN", regWEN, 1);
    @(negedge CLK);
    dhit = 1'b0;
    #1;
    check("tod_err", timeout_err, 0);
    check("tod_halt", halt, 0);
    check("tod_retire", retire_cnt, 1);
    check("tod_imemREN", imemREN, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
